// File: rtl/ctrl_pkg.sv
// Shared definitions for the push-button conditioner, the player stage and the benches:
// direction indices, repeat FSM state encoding and default timing constants.
package ctrl_pkg;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;
  localparam int unsigned NumDirs   = 4;

  // 25 MHz system clock: 10 ms debounce, 500 ms first repeat, 100 ms repeat period
  localparam int unsigned DefDebounceCycles = 250000;
  localparam int unsigned DefRepeatDelay    = 12500000;
  localparam int unsigned DefRepeatPeriod   = 2500000;
  localparam int unsigned DefCntW           = 24;

  // RptHeld is only reached when auto-repeat is compiled out
  typedef enum logic [1:0] {
    RptIdle   = 2'd0,
    RptDelay  = 2'd1,
    RptRepeat = 2'd2,
    RptHeld   = 2'd3
  } rpt_state_e;

  // Opposing pairs are {up,down} and {left,right}
  function automatic int unsigned opp_dir(input int unsigned dir);
    return dir ^ 32'd1;
  endfunction

endpackage

// File: rtl/ctrl_debounce.sv
// One button: two-flop synchroniser, debounce counter and rising-edge detect of the
// debounced level.
module ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic held_o,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             held_q, held_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    held_d = held_q;
    rise_d = 1'b0;
    cnt_d  = '0;
    if (sync2_q != held_q) begin
      // The level flips on the edge that would make the count reach DEBOUNCE_CYCLES
      if (cnt_q == CntLast) begin
        held_d = ~held_q;
        rise_d = ~held_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      held_q  <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      held_q  <= held_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign held_o = held_q;
  assign rise_o = rise_q;

endmodule

// File: rtl/ctrl_conditioner.sv
// Four-button conditioner producing single-cycle step pulses with opposition masking.
// Define AUTOREPEAT_EN to build the DELAY/REPEAT auto-repeat timers.
module ctrl_conditioner
  import ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       ctrl_up,
  output logic       ctrl_down,
  output logic       ctrl_left,
  output logic       ctrl_right,
  output logic [3:0] btn_held
);

  if (CNT_W < $clog2(DEBOUNCE_CYCLES + 1) || CNT_W < $clog2(REPEAT_DELAY + 1) ||
      CNT_W < $clog2(REPEAT_PERIOD + 1)) begin : g_cnt_w_too_narrow
    $error("CNT_W cannot hold the largest timing constant");
  end

  logic [NumDirs-1:0] btn_raw, held, rise, pulse_raw;
  logic [NumDirs-1:0] ctrl_q, ctrl_d;

  assign btn_raw[DIR_UP]    = btn_up;
  assign btn_raw[DIR_DOWN]  = btn_down;
  assign btn_raw[DIR_LEFT]  = btn_left;
  assign btn_raw[DIR_RIGHT] = btn_right;

  for (genvar i = 0; i < NumDirs; i++) begin : g_dir
    localparam int unsigned Opp = opp_dir(i);

    ctrl_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk_i (clk),
      .rst_ni(reset),
      .btn_i (btn_raw[i]),
      .held_o(held[i]),
      .rise_o(rise[i])
    );

    // A pulse is dropped, not deferred, while the opposing button is held
    assign ctrl_d[i] = pulse_raw[i] & ~held[Opp];

    rpt_state_e state_q, state_d;

`ifdef AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] DelayLast  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PeriodLast = CNT_W'(REPEAT_PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      pulse_raw[i] = 1'b0;
      if (!held[i]) begin
        state_d = RptIdle;
        cnt_d   = '0;
      end else begin
        case (state_q)
          RptIdle: begin
            if (rise[i]) begin
              pulse_raw[i] = 1'b1;
              state_d      = RptDelay;
              cnt_d        = '0;
            end
          end
          RptDelay: begin
            if (cnt_q == DelayLast) begin
              pulse_raw[i] = 1'b1;
              state_d      = RptRepeat;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          RptRepeat: begin
            if (cnt_q == PeriodLast) begin
              pulse_raw[i] = 1'b1;
              cnt_d        = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = RptIdle;
            cnt_d   = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= RptIdle;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
      end
    end
`else
    always_comb begin
      state_d      = state_q;
      pulse_raw[i] = 1'b0;
      if (!held[i]) begin
        state_d = RptIdle;
      end else if (state_q == RptIdle && rise[i]) begin
        pulse_raw[i] = 1'b1;
        state_d      = RptHeld;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q <= RptIdle;
      end else begin
        state_q <= state_d;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ctrl_up    = ctrl_q[DIR_UP];
  assign ctrl_down  = ctrl_q[DIR_DOWN];
  assign ctrl_left  = ctrl_q[DIR_LEFT];
  assign ctrl_right = ctrl_q[DIR_RIGHT];
  assign btn_held   = held;

endmodule

// File: tb/tb_ctrl_conditioner.sv
// Scoreboard bench for ctrl_conditioner: per-edge expected pulses and debounced levels are
// queued as buttons are driven and compared one edge later.
module tb_ctrl_conditioner;
  import ctrl_pkg::*;

  localparam int unsigned Db = 4;
  localparam int unsigned Rd = 20;
  localparam int unsigned Rp = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       ctrl_up, ctrl_down, ctrl_left, ctrl_right;
  logic [3:0] btn_held;
  logic [3:0] ctrl_vec;

  assign ctrl_vec = {ctrl_right, ctrl_left, ctrl_down, ctrl_up};

  always #5 clk = ~clk;

  ctrl_conditioner #(
    .DEBOUNCE_CYCLES(Db),
    .REPEAT_DELAY   (Rd),
    .REPEAT_PERIOD  (Rp),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .ctrl_up   (ctrl_up),
    .ctrl_down (ctrl_down),
    .ctrl_left (ctrl_left),
    .ctrl_right(ctrl_right),
    .btn_held  (btn_held)
  );

  typedef struct packed {
    logic [3:0] ctrl;
    logic [3:0] held;
  } exp_t;

  exp_t       exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         on_e[4];
  int         off_e[4];
  logic [3:0] pulse_at[0:127];

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Raw level sampled at edge e (edge 1 is the first edge of a frame)
  function automatic logic raw_at(input int d, input int e);
    return (e >= on_e[d]) && (e < off_e[d]);
  endfunction

  // Debounced level after edge e: 2 sync edges then Db counting edges
  function automatic logic held_at(input int d, input int e);
    return (off_e[d] - on_e[d] >= int'(Db)) && (e >= on_e[d] + int'(Db) + 1) &&
           (e < off_e[d] + int'(Db) + 1);
  endfunction

  task automatic clear_frame();
    for (int d = 0; d < 4; d++) begin
      on_e[d]  = 0;
      off_e[d] = 0;
    end
    for (int e = 0; e < 128; e++) pulse_at[e] = 4'b0000;
  endtask

  task automatic set_btn(input int d, input int on, input int off);
    on_e[d]  = on;
    off_e[d] = off;
  endtask

  task automatic add_pulse(input int d, input int e);
    pulse_at[e][d] = 1'b1;
  endtask

  task automatic run_frame(input string name, input int n);
    for (int e = 1; e <= n; e++) begin
      exp_t x;
      btn_up    = raw_at(DIR_UP, e);
      btn_down  = raw_at(DIR_DOWN, e);
      btn_left  = raw_at(DIR_LEFT, e);
      btn_right = raw_at(DIR_RIGHT, e);
      x.ctrl = pulse_at[e];
      for (int d = 0; d < 4; d++) x.held[d] = held_at(d, e);
      exp_q.push_back(x);
      @(posedge clk);
      #1;
      x = exp_q.pop_front();
      check_eq($sformatf("%s.ctrl@%0d", name, e), ctrl_vec, x.ctrl);
      check_eq($sformatf("%s.held@%0d", name, e), btn_held, x.held);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_frame();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst.ctrl", ctrl_vec, 4'b0000);
    check_eq("rst.held", btn_held, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    clear_frame();
    run_frame("idle", 10);

    clear_frame();
    set_btn(DIR_UP, 1, 3);
    run_frame("glitch", 12);

    clear_frame();
    set_btn(DIR_UP, 1, 61);
    add_pulse(DIR_UP, 7);
`ifdef AUTOREPEAT_EN
    add_pulse(DIR_UP, 28);
    for (int e = 34; e <= 64; e += 6) add_pulse(DIR_UP, e);
`endif
    run_frame("hold", 70);

    clear_frame();
    set_btn(DIR_UP, 1, 67);
    set_btn(DIR_DOWN, 1, 41);
`ifdef AUTOREPEAT_EN
    for (int e = 52; e <= 70; e += 6) add_pulse(DIR_UP, e);
`endif
    run_frame("oppose", 80);

    clear_frame();
    set_btn(DIR_UP, 1, 11);
    set_btn(DIR_LEFT, 1, 11);
    add_pulse(DIR_UP, 7);
    add_pulse(DIR_LEFT, 7);
    run_frame("diag", 20);

    clear_frame();
    set_btn(DIR_RIGHT, 1, 999);
    add_pulse(DIR_RIGHT, 7);
`ifdef AUTOREPEAT_EN
    add_pulse(DIR_RIGHT, 28);
    add_pulse(DIR_RIGHT, 34);
`endif
    run_frame("pre_rst", 34);
    #1;
    reset = 1'b0;
    #1;
    check_eq("async_rst.ctrl", ctrl_vec, 4'b0000);
    check_eq("async_rst.held", btn_held, 4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    clear_frame();
    set_btn(DIR_RIGHT, 1, 21);
    add_pulse(DIR_RIGHT, 7);
    run_frame("post_rst", 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
